// File: rtl/interleave_ctrl.sv
// Block-interleaver controller. Accepts ROWS*COLS words and writes them to a
// single-port RAM in row-major order. It then reads the frame back in
// column-major order and streams the words out with last-word marking.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_data/in_valid/in_ready       upstream stream
//   ram_addr/ram_cs_n/ram_rd        RAM control (cs_n active low, rd=1 read)
//   ram_wdata/ram_rdata             RAM data; read data arrives one cycle after the address
//   out_data/out_valid/out_ready    interleaved output stream
//   out_last                        final word of a frame (qualified by out_valid)
//   frame_done                      one-cycle pulse after the final word is accepted
module interleave_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned ROWS   = 83,
  parameter int unsigned COLS   = 148
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs_n,
  output logic              ram_rd,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              frame_done
);

  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);

  typedef enum logic {S_WRITE, S_READ} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [CNT_W-1:0]  issued;
  logic              pending;
  logic              pending_last;
  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_last [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;

  logic       accept;
  logic       wr_last;
  logic       pop;
  logic       issue;
  logic       issue_last;
  logic [2:0] load;

  // Output stream is the head of the 2-entry FIFO
  assign out_valid = (occ != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = out_valid & fifo_last[rd_ptr];
  assign pop       = out_valid & out_ready;

  assign accept  = in_valid & in_ready;
  assign wr_last = (wr_addr == ADDR_W'(N - 1));

  // Words held or in flight after this cycle's pop; counting the pop lets
  // issue continue every cycle while the consumer keeps up.
  assign load       = 3'(occ) + 3'(pending) - 3'(pop);
  assign issue_last = (issued == CNT_W'(N - 1));
  assign issue      = (state == S_READ) && (load < 3'd2) && (issued < CNT_W'(N));

  // RAM control: writes only on accepted words, continuous reads in READ
  always_comb begin
    ram_cs_n  = 1'b1;
    ram_rd    = 1'b0;
    ram_addr  = wr_addr;
    ram_wdata = in_data;
    if (state == S_READ) begin
      ram_cs_n = 1'b0;
      ram_rd   = 1'b1;
      ram_addr = rd_addr;
    end else if (accept) begin
      ram_cs_n = 1'b0;
    end
  end

  // Frame FSM, address generation and output FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_WRITE;
      in_ready     <= 1'b0;
      frame_done   <= 1'b0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      row          <= '0;
      col          <= '0;
      issued       <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      occ          <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_WRITE: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (wr_last) begin
              wr_addr  <= '0;
              state    <= S_READ;
              in_ready <= 1'b0;
            end else begin
              wr_addr <= wr_addr + ADDR_W'(1);
            end
          end
        end
        S_READ: begin
          pending      <= issue;
          pending_last <= issue & issue_last;
          if (issue) begin
            issued <= issued + CNT_W'(1);
            // Column-major walk by addition: step a row, or wrap to the next column
            if (row == ROW_W'(ROWS - 1)) begin
              row     <= '0;
              col     <= col + COL_W'(1);
              rd_addr <= ADDR_W'(col) + ADDR_W'(1);
            end else begin
              row     <= row + ROW_W'(1);
              rd_addr <= rd_addr + ADDR_W'(COLS);
            end
          end
          if (pending) begin
            fifo_data[wr_ptr] <= ram_rdata;
            fifo_last[wr_ptr] <= pending_last;
            wr_ptr            <= ~wr_ptr;
          end
          if (pop) begin
            rd_ptr <= ~rd_ptr;
          end
          occ <= occ + 2'(pending) - 2'(pop);
          if (pop && out_last) begin
            frame_done   <= 1'b1;
            state        <= S_WRITE;
            in_ready     <= 1'b1;
            rd_addr      <= '0;
            row          <= '0;
            col          <= '0;
            issued       <= '0;
            pending      <= 1'b0;
            pending_last <= 1'b0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            occ          <= '0;
          end
        end
        default: state <= S_WRITE;
      endcase
    end
  end

endmodule

// File: tb/tb_interleave_ctrl.sv
// Self-checking bench for interleave_ctrl: a 3x4 instance for detailed
// protocol checks and a default 83x148 instance for back-to-back frames.
module tb_interleave_ctrl;

  localparam int unsigned SR = 3;
  localparam int unsigned SC = 4;
  localparam int unsigned SN = SR * SC;
  localparam int unsigned LR = 83;
  localparam int unsigned LC = 148;
  localparam int unsigned LN = LR * LC;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Small instance signals
  logic [31:0] s_in_data, s_ram_wdata, s_ram_rdata, s_out_data;
  logic        s_in_valid, s_in_ready, s_ram_cs_n, s_ram_rd;
  logic        s_out_valid, s_out_ready, s_out_last, s_frame_done;
  logic [13:0] s_ram_addr;
  // Large instance signals
  logic [31:0] l_in_data, l_ram_wdata, l_ram_rdata, l_out_data;
  logic        l_in_valid, l_in_ready, l_ram_cs_n, l_ram_rd;
  logic        l_out_valid, l_out_ready, l_out_last, l_frame_done;
  logic [13:0] l_ram_addr;

  interleave_ctrl #(.DATA_W(32), .ADDR_W(14), .ROWS(SR), .COLS(SC)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .ram_addr(s_ram_addr), .ram_cs_n(s_ram_cs_n), .ram_rd(s_ram_rd),
    .ram_wdata(s_ram_wdata), .ram_rdata(s_ram_rdata),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_last(s_out_last), .frame_done(s_frame_done)
  );

  interleave_ctrl dut_l (
    .clk(clk), .rst_n(rst_n),
    .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .ram_addr(l_ram_addr), .ram_cs_n(l_ram_cs_n), .ram_rd(l_ram_rd),
    .ram_wdata(l_ram_wdata), .ram_rdata(l_ram_rdata),
    .out_data(l_out_data), .out_valid(l_out_valid), .out_ready(l_out_ready),
    .out_last(l_out_last), .frame_done(l_frame_done)
  );

  // Synchronous single-port RAM models
  logic [31:0] s_mem [0:15];
  logic [31:0] l_mem [0:16383];
  always @(posedge clk) begin
    if (!s_ram_cs_n) begin
      if (s_ram_rd) s_ram_rdata <= s_mem[s_ram_addr[3:0]];
      else          s_mem[s_ram_addr[3:0]] <= s_ram_wdata;
    end
    if (!l_ram_cs_n) begin
      if (l_ram_rd) l_ram_rdata <= l_mem[l_ram_addr];
      else          l_mem[l_ram_addr] <= l_ram_wdata;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned seq_s(input int unsigned k);
    return (k % SR) * SC + k / SR;
  endfunction

  function automatic int unsigned seq_l(input int unsigned k);
    return (k % LR) * LC + k / LR;
  endfunction

  function automatic logic [31:0] mk_l(input int f, input int unsigned a);
    return (32'(f) << 28) | 32'(a);
  endfunction

  logic [32:0] exp_s[$];
  logic [32:0] exp_l[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Small-instance monitor: read-address order, occupancy, scoreboard, frame end
  int          iss = 0, fpop = 0, s_done = 0, first_pop_cyc = 0, last_pop_cyc = 0;
  bit          prev_rd = 1'b0;
  logic [13:0] prev_addr;
  logic [32:0] s_item;
  always @(negedge clk) begin
    if (!rst_n) begin
      iss = 0; fpop = 0; prev_rd = 1'b0;
    end else begin
      if (s_ram_rd && !s_ram_cs_n) begin
        if (!prev_rd) begin
          prev_addr = s_ram_addr;
          iss = 0;
        end else if (s_ram_addr != prev_addr) begin
          check("s_rd_seq", 64'(prev_addr), 64'(seq_s(iss)));
          iss++;
          prev_addr = s_ram_addr;
        end
        check("s_occ_le2", 64'((iss - fpop) > 2), 64'd0);
        prev_rd = 1'b1;
      end else begin
        prev_rd = 1'b0;
      end
      if (s_out_valid && s_out_ready) begin
        if (exp_s.size() == 0) begin
          check("s_unexpected_word", 64'(exp_s.size()), 64'd1);
        end else begin
          s_item = exp_s.pop_front();
          check("s_out_data", 64'(s_out_data), 64'(s_item[31:0]));
          check("s_out_last", 64'(s_out_last), 64'(s_item[32]));
        end
        if (fpop == 0) first_pop_cyc = cyc;
        fpop++;
        if (s_out_last) last_pop_cyc = cyc;
      end
      if (s_frame_done) begin
        s_done++;
        check("s_done_gap", 64'(cyc - last_pop_cyc), 64'd1);
        check("s_done_ready", 64'(s_in_ready), 64'd1);
        fpop = 0;
      end
    end
  end

  // Large-instance monitor
  int          l_done = 0;
  logic [32:0] l_item;
  always @(negedge clk) begin
    if (rst_n) begin
      if (l_out_valid && l_out_ready) begin
        if (exp_l.size() == 0) begin
          check("l_unexpected_word", 64'(exp_l.size()), 64'd1);
        end else begin
          l_item = exp_l.pop_front();
          check("l_out_data", 64'(l_out_data), 64'(l_item[31:0]));
          check("l_out_last", 64'(l_out_last), 64'(l_item[32]));
          if (l_out_last) check("l_last_addr", 64'(l_out_data[13:0]), 64'd12283);
        end
      end
      if (l_frame_done) l_done++;
    end
  end

  // Write one small frame of base+i, optionally with two idle cycles before each word
  task automatic s_write(input logic [31:0] base, input bit gap);
    logic [32:0] e;
    for (int k = 0; k < SN; k++) begin
      e = {(k == SN - 1), base + 32'(seq_s(k))};
      exp_s.push_back(e);
    end
    for (int i = 0; i < SN; i++) begin
      if (gap) begin
        repeat (2) begin
          @(posedge clk); #1;
          s_in_valid = 1'b0;
          @(negedge clk);
          check("s_gap_cs_n", 64'(s_ram_cs_n), 64'd1);
        end
      end
      @(posedge clk); #1;
      s_in_valid = 1'b1;
      s_in_data  = base + 32'(i);
      @(negedge clk);
      check("s_wr_ready", 64'(s_in_ready), 64'd1);
      check("s_wr_cs_n", 64'(s_ram_cs_n), 64'd0);
      check("s_wr_rd", 64'(s_ram_rd), 64'd0);
      check("s_wr_addr", 64'(s_ram_addr), 64'(i));
      check("s_wr_data", 64'(s_ram_wdata), 64'(base + 32'(i)));
    end
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    @(negedge clk);
    check("s_ready_drop", 64'(s_in_ready), 64'd0);
  endtask

  // Drain the small frame with out_ready held high or randomised
  task automatic s_drain(input bit rnd);
    int d0 = s_done;
    int g = 0;
    while (s_done == d0 && g < 300) begin
      @(posedge clk); #1;
      s_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk); #1;
      g++;
    end
    check("s_drain_done", 64'(s_done - d0), 64'd1);
    check("s_q_empty", 64'(exp_s.size()), 64'd0);
    s_out_ready = 1'b1;
  endtask

  // Write one large frame; waits out the previous frame's drain via in_ready
  task automatic l_frame(input int f);
    logic [32:0] e;
    int i = 0;
    int g = 0;
    for (int k = 0; k < LN; k++) begin
      e = {(k == LN - 1), mk_l(f, seq_l(k))};
      exp_l.push_back(e);
    end
    while (i < LN && g < 3 * LN) begin
      @(posedge clk); #1;
      l_in_valid = 1'b1;
      l_in_data  = mk_l(f, i);
      @(negedge clk);
      if (l_in_ready) i++;
      g++;
    end
    @(posedge clk); #1;
    l_in_valid = 1'b0;
    check("l_wr_count", 64'(i), 64'(LN));
  endtask

  initial begin
    int g;
    rst_n = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    l_in_valid = 1'b0; l_in_data = '0; l_out_ready = 1'b1;
    #2;
    check("rst_in_ready", 64'(s_in_ready), 64'd0);
    check("rst_out_valid", 64'(s_out_valid), 64'd0);
    check("rst_out_data", 64'(s_out_data), 64'd0);
    check("rst_out_last", 64'(s_out_last), 64'd0);
    check("rst_frame_done", 64'(s_frame_done), 64'd0);
    check("rst_cs_n", 64'(s_ram_cs_n), 64'd1);
    check("rst_rd", 64'(s_ram_rd), 64'd0);
    check("rst_addr", 64'(s_ram_addr), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Straight frame, full-rate drain
    s_write(32'h100, 1'b0);
    @(negedge clk);
    check("s_lat_valid_r1", 64'(s_out_valid), 64'd0);
    @(negedge clk);
    check("s_lat_valid_r2", 64'(s_out_valid), 64'd1);
    s_drain(1'b0);
    check("s_burst_span", 64'(last_pop_cyc - first_pop_cyc), 64'(SN - 1));

    // Random backpressure, then gapped input
    s_write(32'h200, 1'b0);
    s_drain(1'b1);
    s_write(32'h300, 1'b1);
    s_drain(1'b0);

    // Reset in the middle of readout
    s_write(32'h400, 1'b0);
    g = 0;
    while (iss < 5 && g < 60) begin
      @(negedge clk); #1;
      g++;
    end
    check("s_iss5_reached", 64'(iss >= 5), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_s.delete();
    #1;
    check("mid_rst_out_valid", 64'(s_out_valid), 64'd0);
    check("mid_rst_cs_n", 64'(s_ram_cs_n), 64'd1);
    check("mid_rst_in_ready", 64'(s_in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_in_ready", 64'(s_in_ready), 64'd1);
    check("post_rst_rd", 64'(s_ram_rd), 64'd0);
    check("post_rst_out_valid", 64'(s_out_valid), 64'd0);
    s_write(32'h500, 1'b0);
    s_drain(1'b1);
    check("s_done_total", 64'(s_done), 64'd4);

    // Default geometry, two back-to-back frames
    l_frame(0);
    l_frame(1);
    g = 0;
    while (l_done < 2 && g < LN + 100) begin
      @(negedge clk); #1;
      g++;
    end
    check("l_done_cnt", 64'(l_done), 64'd2);
    check("l_q_empty", 64'(exp_l.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interleave_ctrl.md
Name: interleave_ctrl

Overview:
- Block-interleaver controller; sits directly upstream of the 12284 x 32 single-port interleaver RAM.
- Accepts one frame of ROWS*COLS words over a valid/ready stream and writes them to RAM in row-major order.
- Reads the frame back in column-major order and presents the interleaved words on a valid/ready output stream with last-word marking.
- Drives the RAM's active-low chip select, read/write select, address and write data; captures the RAM read data.

Parameters:
- DATA_W, 32, word width.
- ADDR_W, 14, RAM address width.
- ROWS, 83, interleaver rows; ROWS >= 2.
- COLS, 148, interleaver columns; COLS >= 2; ROWS*COLS <= 12284.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  upstream word.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block accepts in_data this cycle.
- ram_addr  output  ADDR_W  RAM address.
- ram_cs_n  output  1  RAM chip select, active low.
- ram_rd  output  1  1 = read, 0 = write.
- ram_wdata  output  DATA_W  RAM write data.
- ram_rdata  input  DATA_W  RAM read data; valid while ram_cs_n=0 and ram_rd=1.
- out_data  output  DATA_W  interleaved word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_last  output  1  marks the final word of a frame; qualified by out_valid.
- frame_done  output  1  one-cycle pulse when the final word is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - State = WRITE; all counters and the output buffer are cleared.
  - in_ready=0 while rst_n=0.
  - out_valid=0, out_data=0, out_last=0, frame_done=0.
  - ram_cs_n=1, ram_rd=0, ram_addr=0.
  - Asserting reset mid-frame aborts the frame; no partial output is emitted after release.
- N = ROWS*COLS.
- WRITE state:
  - in_ready=1.
  - Accept = in_valid & in_ready.
  - On accept, combinationally: ram_cs_n=0, ram_rd=0, ram_addr=wr_addr, ram_wdata=in_data.
  - With no accept: ram_cs_n=1.
  - wr_addr starts at 0 and increments by 1 per accept.
  - The accept at wr_addr=N-1 moves the state to READ next cycle and clears wr_addr.
- READ state:
  - in_ready=0; ram_cs_n=0 and ram_rd=1 continuously.
  - ram_addr = rd_addr register, initialised to 0.
  - Column-major sequence, computed without a multiplier:
    - rd_addr += COLS while row < ROWS-1.
    - On row wrap: row=0, col+=1, rd_addr=col+1.
  - Address order: 0, COLS, 2*COLS, ..., (ROWS-1)*COLS, 1, COLS+1, ..., N-1.
- Read issue:
  - An issue occurs in a cycle when (buffer occupancy + pending) < 2 and issued count < N.
  - rd_addr advances at the end of an issue cycle; otherwise it holds.
  - The RAM re-reading the held address is harmless.
- Read latency:
  - Data for an issue in cycle T is taken from ram_rdata in cycle T+1 into a 2-entry output FIFO.
  - The pending flag covers the one read in flight.
- Output:
  - out_valid = FIFO non-empty; out_data/out_last come from the FIFO head.
  - Sustained throughput is 1 word/clk with out_ready=1.
  - First out_valid appears 2 cycles after entering READ.
  - out_ready=0 stalls issue once the FIFO plus pending reaches 2; no word is lost or duplicated.
  - out_last=1 only on the word from address N-1.
- Frame end:
  - On accept of the last word (out_valid & out_ready & out_last): frame_done=1 for one cycle.
  - State returns to WRITE next cycle and all read counters clear.
- No overlap: a new frame is not accepted until the previous frame has fully drained; in_ready=0 throughout READ.
- Simultaneous FIFO push and pop in one cycle keeps occupancy unchanged.

Test Plan:
- ROWS=3, COLS=4, write words 0x100+i for i=0..11 with in_valid held high -> ram_addr writes 0..11 on consecutive cycles with ram_cs_n=0, ram_rd=0; in_ready drops the cycle after the 12th accept.
- Same frame, out_ready=1 -> out_data sequence 0x100,0x104,0x108,0x101,0x105,0x109,0x102,0x106,0x10A,0x103,0x107,0x10B on 12 consecutive cycles; out_last only on 0x10B; frame_done pulses once; in_ready=1 on the following cycle.
- Random out_ready (50%) -> same 12-word order; no drops or duplicates; ram_addr holds while stalled; FIFO occupancy never exceeds 2.
- in_valid gapped (1 of 3 cycles) during WRITE -> ram_cs_n=1 in the gap cycles; wr_addr stays contiguous 0..11.
- rst_n pulsed low after 5 reads issued -> out_valid=0 and ram_cs_n=1 immediately; after release state=WRITE, in_ready=1; a new frame interleaves correctly from address 0.
- Default ROWS=83, COLS=148, two back-to-back frames -> every output index k maps to address (k mod 83)*148 + k/83; final address 12283; two frame_done pulses.
